// File: rtl/keypad_scanner.sv
// ----------------------------------------------------------------------------
// keypad_scanner
//
// Purpose
//   Scans a 4x4 matrix keypad: one column strobe is driven low at a time,
//   the row lines are read back through a two-flop synchronizer, a full
//   four-column frame is reduced to a single key candidate, and the
//   candidate is debounced over consecutive frames. Every accepted press
//   produces a one-cycle key_valid pulse together with its 4-bit key_code.
//
// Parameters
//   SETTLE_CYCLES   cycles each column is driven before its rows are sampled (4..65535)
//   DEBOUNCE_SCANS  identical consecutive frames needed to accept a change   (1..255)
//   REPEAT_SCANS    frames between auto-repeat pulses (auto-repeat build only)
//
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous, active-high reset
//   row_n      in   4  keypad rows, active low, externally pulled up
//   col_n      out  4  column strobes, active low, exactly one low at a time
//   key_valid  out  1  one-cycle pulse when a debounced key is accepted
//   key_code   out  4  code of the last accepted key, held until the next one
//   key_held   out  1  high while the accepted key remains debounced-pressed
//
// Build option
//   KEYPAD_REPEAT_EN  when defined, key_valid re-pulses every REPEAT_SCANS
//                     frames while the key stays held. When undefined there
//                     is exactly one pulse per press and no repeat counter.
//
// Key map (row r, column c):
//   r0: 1 2 3 A
//   r1: 4 5 6 B
//   r2: 7 8 9 C
//   r3: 0 F E D
// ----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 20,
    parameter int unsigned REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    // Reject illegal configurations at elaboration time.
    if (SETTLE_CYCLES < 4 || SETTLE_CYCLES > 65535) begin : g_badSettle
        $error("keypad_scanner: SETTLE_CYCLES must be within 4..65535");
    end
    if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255) begin : g_badDebounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be within 1..255");
    end
    if (REPEAT_SCANS < 1 || REPEAT_SCANS > 65535) begin : g_badRepeat
        $error("keypad_scanner: REPEAT_SCANS must be within 1..65535");
    end

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  DEB_TARGET  = 8'(DEBOUNCE_SCANS);

    // Candidate encoding: bit 4 set means "no single key" (NONE).
    localparam logic [4:0]  CAND_NONE   = 5'b1_0000;

    typedef enum logic [1:0] {
        SCAN_COL0 = 2'd0,
        SCAN_COL1 = 2'd1,
        SCAN_COL2 = 2'd2,
        SCAN_COL3 = 2'd3
    } scanState_t;

    // ------------------------------------------------------------------
    // Row synchronizer
    // ------------------------------------------------------------------
    logic [3:0] rowSync1_q;
    logic [3:0] rowSync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowSync1_q <= 4'hF;
            rowSync2_q <= 4'hF;
        end else begin
            rowSync1_q <= row_n;
            rowSync2_q <= rowSync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Column scan FSM
    // The snapshot holds one nibble per column; bit 4c+r is set when row r
    // read low while column c was strobed. frameDone_q flags the cycle right
    // after column 3 has been captured, when the snapshot is complete.
    // ------------------------------------------------------------------
    scanState_t  scanState_q;
    logic [15:0] settleCnt_q;
    logic [3:0]  colN_q;
    logic [15:0] snapshot_q;
    logic        frameDone_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scanState_q <= SCAN_COL0;
            settleCnt_q <= 16'd0;
            colN_q      <= 4'b1110;
            snapshot_q  <= 16'd0;
            frameDone_q <= 1'b0;
        end else begin
            frameDone_q <= 1'b0;
            if (settleCnt_q == SETTLE_LAST) begin
                settleCnt_q <= 16'd0;
                case (scanState_q)
                    SCAN_COL0: begin
                        snapshot_q[3:0]   <= ~rowSync2_q;
                        scanState_q       <= SCAN_COL1;
                        colN_q            <= 4'b1101;
                    end
                    SCAN_COL1: begin
                        snapshot_q[7:4]   <= ~rowSync2_q;
                        scanState_q       <= SCAN_COL2;
                        colN_q            <= 4'b1011;
                    end
                    SCAN_COL2: begin
                        snapshot_q[11:8]  <= ~rowSync2_q;
                        scanState_q       <= SCAN_COL3;
                        colN_q            <= 4'b0111;
                    end
                    SCAN_COL3: begin
                        snapshot_q[15:12] <= ~rowSync2_q;
                        scanState_q       <= SCAN_COL0;
                        colN_q            <= 4'b1110;
                        frameDone_q       <= 1'b1;
                    end
                    default: begin
                        scanState_q       <= SCAN_COL0;
                        colN_q            <= 4'b1110;
                    end
                endcase
            end else begin
                settleCnt_q <= settleCnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame evaluation
    // ------------------------------------------------------------------
    function automatic logic [3:0] codeOf(input logic [3:0] bitIdx);
        // bitIdx = 4*column + row
        logic [3:0] code;
        case (bitIdx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h4;
            4'd2:    code = 4'h7;
            4'd3:    code = 4'h0;
            4'd4:    code = 4'h2;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h8;
            4'd7:    code = 4'hF;
            4'd8:    code = 4'h3;
            4'd9:    code = 4'h6;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hE;
            4'd12:   code = 4'hA;
            4'd13:   code = 4'hB;
            4'd14:   code = 4'hC;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [4:0] cand;
    logic       anyBit;
    logic       multiBit;

    // Zero bits or more than one bit (chord or ghost) both map to NONE.
    always_comb begin
        anyBit   = 1'b0;
        multiBit = 1'b0;
        cand     = CAND_NONE;
        for (int i = 0; i < 16; i++) begin
            if (snapshot_q[i]) begin
                if (anyBit) begin
                    multiBit = 1'b1;
                end
                anyBit = 1'b1;
                cand   = {1'b0, codeOf(4'(i))};
            end
        end
        if (multiBit || !anyBit) begin
            cand = CAND_NONE;
        end
    end

    // ------------------------------------------------------------------
    // Debounce and accept
    // ------------------------------------------------------------------
    logic [4:0] prevCand_q,  prevCand_d;
    logic [7:0] stableCnt_q, stableCnt_d;
    logic [3:0] keyCode_q,   keyCode_d;
    logic       keyHeld_q,   keyHeld_d;
    logic       keyValid_q,  keyValid_d;
    logic       pressPulse;
    logic       repeatFire;
    logic       sameCand;

    // An accept fires only on the frame where the count reaches the target;
    // the guard on the old count stops a saturated count of 255 from
    // re-accepting every frame when the target is 255.
    always_comb begin
        prevCand_d  = prevCand_q;
        stableCnt_d = stableCnt_q;
        keyCode_d   = keyCode_q;
        keyHeld_d   = keyHeld_q;
        pressPulse  = 1'b0;
        sameCand    = (cand == prevCand_q);
        if (frameDone_q) begin
            prevCand_d = cand;
            if (sameCand) begin
                stableCnt_d = (stableCnt_q == 8'hFF) ? 8'hFF : stableCnt_q + 8'd1;
            end else begin
                stableCnt_d = 8'd1;
            end
            if (stableCnt_d == DEB_TARGET && !(sameCand && stableCnt_q == DEB_TARGET)) begin
                if (cand[4]) begin
                    keyHeld_d = 1'b0;
                end else begin
                    // Re-accepting the key already held is silent.
                    if (cand[3:0] != keyCode_q || !keyHeld_q) begin
                        pressPulse = 1'b1;
                    end
                    keyCode_d = cand[3:0];
                    keyHeld_d = 1'b1;
                end
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: counts frames since the last press pulse while held.
    // ------------------------------------------------------------------
    localparam logic [15:0] RPT_LAST = 16'(REPEAT_SCANS - 1);

    logic [15:0] repeatCnt_q, repeatCnt_d;

    always_comb begin
        repeatCnt_d = repeatCnt_q;
        repeatFire  = 1'b0;
        if (pressPulse || !keyHeld_d) begin
            repeatCnt_d = 16'd0;
        end else if (frameDone_q) begin
            if (repeatCnt_q == RPT_LAST) begin
                repeatFire  = 1'b1;
                repeatCnt_d = 16'd0;
            end else begin
                repeatCnt_d = repeatCnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repeatCnt_q <= 16'd0;
        end else begin
            repeatCnt_q <= repeatCnt_d;
        end
    end
`else
    assign repeatFire = 1'b0;
`endif

    assign keyValid_d = pressPulse | repeatFire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prevCand_q  <= CAND_NONE;
            stableCnt_q <= 8'd0;
            keyCode_q   <= 4'd0;
            keyHeld_q   <= 1'b0;
            keyValid_q  <= 1'b0;
        end else begin
            prevCand_q  <= prevCand_d;
            stableCnt_q <= stableCnt_d;
            keyCode_q   <= keyCode_d;
            keyHeld_q   <= keyHeld_d;
            keyValid_q  <= keyValid_d;
        end
    end

    assign col_n     = colN_q;
    assign key_valid = keyValid_q;
    assign key_code  = keyCode_q;
    assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// ----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SETTLE_CYCLES=4, DEBOUNCE_SCANS=3,
//   REPEAT_SCANS=4 (16-cycle frames). A behavioural keypad pulls a row low
//   whenever a pressed key's column is strobed.
// ----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SETTLE   = 4;
    localparam int DEBOUNCE = 3;
    localparam int REPEAT   = 4;

    // Key positions in keyMat: index = 4*column + row
    localparam int KEY1 = 0;    // r0 c0
    localparam int KEY2 = 4;    // r0 c1
    localparam int KEY0 = 3;    // r3 c0
    localparam int KEY5 = 5;    // r1 c1
    localparam int KEY8 = 6;    // r2 c1
    localparam int KEYD = 15;   // r3 c3

    logic        clk;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] keyMat;

    int checks;
    int errors;
    int pulseCount;
    logic lastValid;

    keypad_scanner #(
        .SETTLE_CYCLES  (SETTLE),
        .DEBOUNCE_SCANS (DEBOUNCE),
        .REPEAT_SCANS   (REPEAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: a pressed key connects its column to its row.
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keyMat[4*c+r] && !col_n[c]) begin
                    row_n[r] = 1'b0;
                end
            end
        end
    end

    // Pulse monitor: counts key_valid pulses and flags back-to-back highs.
    initial begin
        pulseCount = 0;
        lastValid  = 1'b0;
    end
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulseCount = pulseCount + 1;
            checks = checks + 1;
            if (lastValid === 1'b1) begin
                errors = errors + 1;
                $display("[TB] FAIL valid_consecutive: key_valid high %0d cycles in a row, required 1", 2);
            end
        end
        lastValid = key_valid;
    end

    // Returns at the negedge of the first cycle of the next frame (the
    // cycle in which the previous frame is evaluated).
    task automatic waitFrameStart();
        logic [3:0] last;
        bit seen;
        last = col_n;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (col_n == 4'b1110 && last == 4'b0111) seen = 1'b1;
            last = col_n;
        end
        if (!seen) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL frame_timeout: col_n=%b, no frame start within 40 cycles", col_n);
        end
    endtask

    task automatic waitFrames(input int n);
        for (int i = 0; i < n; i++) waitFrameStart();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        keyMat = 16'd0;
        repeat (3) @(negedge clk);
        checks = checks + 4;
        if (col_n !== 4'b1110) begin errors++; $display("[TB] FAIL reset_col: got %b required 1110", col_n); end
        if (key_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", key_valid); end
        if (key_code !== 4'h0) begin errors++; $display("[TB] FAIL reset_code: got %h required 0", key_code); end
        if (key_held !== 1'b0) begin errors++; $display("[TB] FAIL reset_held: got %b required 0", key_held); end
        rst = 1'b0;
    endtask

    // Called right at the reset-release negedge: column index = (cycles/4)%4.
    task automatic test_scan();
        logic [3:0] expCol;
        for (int i = 0; i < 32; i++) begin
            expCol = ~(4'b0001 << ((i / SETTLE) % 4));
            checks = checks + 1;
            if (col_n !== expCol || key_valid !== 1'b0 || key_held !== 1'b0) begin
                errors++;
                $display("[TB] FAIL scan_c%0d: col_n=%b valid=%b held=%b required col_n=%b valid=0 held=0",
                         i, col_n, key_valid, key_held, expCol);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single_press();
        int p0;
        logic expV;
        waitFrameStart();
        keyMat = 16'd1 << KEY8;
        p0 = pulseCount;
        for (int f = 1; f <= 6; f++) begin
            waitFrameStart();
            @(negedge clk);
            expV = (f == DEBOUNCE);
            checks = checks + 1;
            if (key_valid !== expV) begin
                errors++;
                $display("[TB] FAIL press8_valid_f%0d: got %b required %b", f, key_valid, expV);
            end
            if (f >= DEBOUNCE) begin
                checks = checks + 1;
                if (key_code !== 4'h8 || key_held !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL press8_state_f%0d: code=%h held=%b required code=8 held=1", f, key_code, key_held);
                end
            end
        end
        checks = checks + 1;
        if (pulseCount - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL press8_pulses: got %0d required 1", pulseCount - p0);
        end
        // Column 1 is sampled later in this frame, so this frame is already clean.
        keyMat = 16'd0;
        for (int g = 1; g <= 3; g++) begin
            waitFrameStart();
            @(negedge clk);
            checks = checks + 1;
            if (key_held !== (g < 3) || key_code !== 4'h8 || key_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL release8_g%0d: held=%b code=%h valid=%b required held=%b code=8 valid=0",
                         g, key_held, key_code, key_valid, (g < 3));
            end
        end
    endtask

    task automatic test_bounce();
        int p0;
        waitFrameStart();
        p0 = pulseCount;
        for (int rep = 0; rep < 4; rep++) begin
            keyMat = 16'd1 << KEY5;
            waitFrames(2);
            keyMat = 16'd0;
            waitFrames(2);
        end
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (pulseCount - p0 !== 0 || key_held !== 1'b0 || key_code !== 4'h8) begin
            errors++;
            $display("[TB] FAIL bounce5: pulses=%0d held=%b code=%h required pulses=0 held=0 code=8",
                     pulseCount - p0, key_held, key_code);
        end
    endtask

    task automatic test_chord();
        int p0;
        logic expV;
        waitFrameStart();
        p0 = pulseCount;
        keyMat = (16'd1 << KEY1) | (16'd1 << KEY2);
        waitFrames(5);
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (pulseCount - p0 !== 0 || key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL chord12: pulses=%0d held=%b required pulses=0 held=0", pulseCount - p0, key_held);
        end
        waitFrameStart();
        keyMat = 16'd1 << KEY1;
        for (int f = 1; f <= 3; f++) begin
            waitFrameStart();
            @(negedge clk);
            expV = (f == DEBOUNCE);
            checks = checks + 1;
            if (key_valid !== expV) begin
                errors++;
                $display("[TB] FAIL chord_release_valid_f%0d: got %b required %b", f, key_valid, expV);
            end
        end
        checks = checks + 1;
        if (key_code !== 4'h1 || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL chord_release_state: code=%h held=%b required code=1 held=1", key_code, key_held);
        end
        keyMat = 16'd0;
        waitFrames(4);
    endtask

    task automatic test_reset_midscan();
        bit got;
        logic expV;
        waitFrameStart();
        keyMat = 16'd1 << KEYD;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (key_held === 1'b1) got = 1'b1;
        end
        checks = checks + 1;
        if (!got || key_code !== 4'hD) begin
            errors++;
            $display("[TB] FAIL keyD_accept: held=%b code=%h required held=1 code=D", key_held, key_code);
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (col_n === 4'b1011) got = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (!got || col_n !== 4'b1110 || key_held !== 1'b0 || key_code !== 4'h0 || key_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midscan_reset: col_n=%b held=%b code=%h valid=%b required 1110/0/0/0",
                     col_n, key_held, key_code, key_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        // Frames now start at the release; frame 3 is evaluated in cycle 48.
        for (int i = 0; i <= 50; i++) begin
            expV = (i == 49);
            checks = checks + 1;
            if (key_valid !== expV) begin
                errors++;
                $display("[TB] FAIL rearm_valid_c%0d: got %b required %b", i, key_valid, expV);
            end
            @(negedge clk);
        end
        checks = checks + 1;
        if (key_code !== 4'hD || key_held !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rearm_state: code=%h held=%b required code=D held=1", key_code, key_held);
        end
        keyMat = 16'd0;
        waitFrames(4);
    endtask

    task automatic test_repeat();
        logic expV;
        waitFrameStart();
        checks = checks + 1;
        if (key_held !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pre_repeat_held: got %b required 0", key_held);
        end
        keyMat = 16'd1 << KEY0;
        for (int f = 1; f <= 15; f++) begin
            waitFrameStart();
            @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
            expV = (f >= DEBOUNCE) && (((f - DEBOUNCE) % REPEAT) == 0);
`else
            expV = (f == DEBOUNCE);
`endif
            checks = checks + 1;
            if (key_valid !== expV) begin
                errors++;
                $display("[TB] FAIL key0_valid_f%0d: got %b required %b", f, key_valid, expV);
            end
            if (f >= DEBOUNCE) begin
                checks = checks + 1;
                if (key_code !== 4'h0 || key_held !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL key0_state_f%0d: code=%h held=%b required code=0 held=1", f, key_code, key_held);
                end
            end
        end
        keyMat = 16'd0;
        waitFrames(4);
        checks = checks + 1;
        if (key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("[TB] FAIL key0_release: held=%b code=%h required held=0 code=0", key_held, key_code);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        keyMat = 16'd0;
        test_reset();
        test_scan();
        test_single_press();
        test_bounce();
        test_chord();
        test_reset_midscan();
        test_repeat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors = errors + 1;
        $display("[TB] FAIL watchdog: simulation exceeded 400000 time units");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
